operand_loader: RTL

//  Front-end for the magnitude-compare/display datapath. Debounces one push-button and

---
 rtl/operand_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - debounced two-press operand loader (optional OPERAND_TIMEOUT_EN)
module operand_loader #(
    parameter int WIDTH     = 5,
    parameter int DB_CYCLES = 500000,
    parameter int TIMEOUT   = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             valid,
    output logic [1:0]       phase
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        WAIT_X = 2'b00,
        WAIT_Y = 2'b01,
        SHOW   = 2'b10
    } state_t;

    logic             btn_m;
    logic             btn_s;
    logic [WIDTH-1:0] sw_m;
    logic [WIDTH-1:0] sw_s;
    logic [CW-1:0]    cnt;
    logic             db_lvl;
    logic             db_prev;
    logic             press;
    state_t           state;

`ifdef OPERAND_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tmo;
`endif

    // Two-flop synchronisers for the button and the switch bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            sw_m  <= '0;
            sw_s  <= '0;
        end else begin
            btn_m <= btn;
            btn_s <= btn_m;
            sw_m  <= sw;
            sw_s  <= sw_m;
        end
    end

    // Debounce: the level only follows btn_s after an unbroken run of differing samples;
    // the run length lines the debounced edge up two edges after btn_s has settled for DB_CYCLES
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            db_lvl <= 1'b0;
        end else if (btn_s == db_lvl) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_CYCLES)) begin
            db_lvl <= btn_s;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // One-cycle press pulse on the debounced rising edge; a held button yields one press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_prev <= 1'b0;
            press   <= 1'b0;
        end else begin
            db_prev <= db_lvl;
            press   <= db_lvl & ~db_prev;
        end
    end

    // Operand sequencer: one transition per press, operands copied bit-exact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_X;
            x     <= '0;
            y     <= '0;
            valid <= 1'b0;
`ifdef OPERAND_TIMEOUT_EN
            tmo   <= '0;
`endif
        end else begin
            case (state)
                WAIT_X: begin
                    if (press) begin
                        x     <= sw_s;
                        state <= WAIT_Y;
`ifdef OPERAND_TIMEOUT_EN
                        tmo   <= '0;
`endif
                    end
                end
                WAIT_Y: begin
                    if (press) begin
                        y     <= sw_s;
                        valid <= 1'b1;
                        state <= SHOW;
`ifdef OPERAND_TIMEOUT_EN
                        tmo   <= '0;
                    end else if (tmo == TW'(TIMEOUT - 1)) begin
                        // abandon the half-entered pair; y keeps its previous value
                        state <= WAIT_X;
                        tmo   <= '0;
                    end else begin
                        tmo <= tmo + TW'(1);
`endif
                    end
                end
                SHOW: begin
                    if (press) begin
                        valid <= 1'b0;
                        state <= WAIT_X;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= WAIT_X;
                end
            endcase
        end
    end

    assign phase = state;

endmodule
